// File: rtl/alu_iterative.sv
// alu_iterative: execute stage for the ALU control decoder.
// Logic, add, subtract and set-less-than finish in a single cycle.
// Shifts walk one bit per cycle through a shift register so that no barrel
// shifter is needed; busy/done let the datapath stall while a shift runs.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       control_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [SW-1:0]    shift_cnt;
  logic [3:0]       shift_op;
  logic [WIDTH-1:0] alu_value;
  logic             alu_illegal;
  logic             accept;
  logic             is_shift_in;
  logic             multi_cycle;
  logic [SW-1:0]    shift_amt;
  logic             last_shift;

  assign accept      = start && ((state == IDLE) || (state == DONE));
  assign is_shift_in = (control_in == OP_SLL) || (control_in == OP_SRL) ||
                       (control_in == OP_SRA);
  assign shift_amt   = b[SW-1:0];
  assign multi_cycle = is_shift_in && (shift_amt != '0);
  assign last_shift  = (shift_cnt == SW'(1));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Single-cycle result; a zero-length shift simply passes a through
  always_comb begin
    alu_value   = '0;
    alu_illegal = 1'b0;
    case (control_in)
      OP_AND:  alu_value = a & b;
      OP_OR:   alu_value = a | b;
      OP_NOR:  alu_value = ~(a | b);
      OP_ADD:  alu_value = a + b;
      OP_SUB:  alu_value = a - b;
      OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_value = a;
      default: begin
        alu_value   = '0;
        alu_illegal = 1'b1;
      end
    endcase
  end

  // One-bit step of the serial shifter in the direction latched at start
  always_comb begin
    shift_next = shift_reg;
    case (shift_op)
      OP_SLL:  shift_next = {shift_reg[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, shift_reg[WIDTH-1:1]};
      OP_SRA:  shift_next = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
      default: shift_next = shift_reg;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start is only looked at in IDLE and DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = multi_cycle ? SHIFT : DONE;
        end else begin
          next_state = IDLE;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch operands on acceptance, step the shifter, and update
  // the visible outputs only on a completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
      shift_reg <= '0;
      shift_cnt <= '0;
      shift_op  <= OP_AND;
    end else if (accept) begin
      if (multi_cycle) begin
        shift_reg <= a;
        shift_cnt <= shift_amt;
        shift_op  <= control_in;
      end else begin
        result  <= alu_value;
        zero    <= (alu_value == '0);
        illegal <= alu_illegal;
      end
    end else if (state == SHIFT) begin
      shift_reg <= shift_next;
      shift_cnt <= shift_cnt - SW'(1);
      if (last_shift) begin
        result  <= shift_next;
        zero    <= (shift_next == '0);
        illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: scoreboard-driven bench for alu_iterative (WIDTH=32).
module tb_alu_iterative;

  localparam int WIDTH = 32;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  control_in;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        illegal;

  int   tests_run;
  int   tests_failed;
  exp_t sbq[$];

  alu_iterative #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .control_in (control_in),
    .a          (a),
    .b          (b),
    .result     (result),
    .zero       (zero),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: straight operators, latency from the shift amount
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t e;
    int   k;
    k     = int'(y[4:0]);
    e.ill = 1'b0;
    e.lat = 1;
    case (c)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b1100: e.res = ~(x | y);
      4'b0010: e.res = x + y;
      4'b0110: e.res = x - y;
      4'b0111: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: begin e.res = x << k;           e.lat = k + 1; end
      4'b1001: begin e.res = x >> k;           e.lat = k + 1; end
      4'b1010: begin e.res = $signed(x) >>> k; e.lat = k + 1; end
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Drive one request, drop start, scramble inputs, and wait (bounded) for done
  task automatic run_op(input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y, output logic [31:0] res,
                        output logic z, output logic ill, output int lat,
                        output int busyc, output bit tout);
    @(negedge clk);
    control_in = c;
    a          = x;
    b          = y;
    start      = 1'b1;
    @(posedge clk);
    lat   = 1;
    busyc = 0;
    #1;
    start      = 1'b0;
    a          = $urandom;
    b          = $urandom;
    control_in = 4'($urandom);
    while (done !== 1'b1 && lat < 2 * WIDTH + 4) begin
      if (busy === 1'b1) busyc++;
      @(posedge clk);
      lat++;
      #1;
    end
    tout = (done !== 1'b1);
    res  = result;
    z    = zero;
    ill  = illegal;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1 || done !== 1'b0 || busy !== 1'b0 ||
        illegal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset: got result=%h zero=%b done=%b busy=%b illegal=%b, want 0 1 0 0 0",
               result, zero, done, busy, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_cycle();
    logic [3:0]  codes[9] = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b1100,
                              4'b0001, 4'b0111, 4'b0011, 4'b0010};
    logic [31:0] xs[9]    = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h0000_F0F0,
                              32'd0, 32'h0000_1200, 32'd1, 32'hDEAD_BEEF, 32'd2};
    logic [31:0] ys[9]    = '{32'd1, 32'd7, 32'd1, 32'h0000_0FF0, 32'd0,
                              32'h0000_0034, 32'hFFFF_FFFF, 32'h1234_5678, 32'd3};
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
    int          busyc;
    bit          tout;
    exp_t        e;
    for (int i = 0; i < 9; i++) begin
      sbq.push_back(model(codes[i], xs[i], ys[i]));
      run_op(codes[i], xs[i], ys[i], res, z, ill, lat, busyc, tout);
      e = sbq.pop_front();
      tests_run++;
      if (tout || res !== e.res || z !== e.z || ill !== e.ill) begin
        tests_failed++;
        $display("[TB] FAIL op%0d code=%b: got result=%h zero=%b illegal=%b timeout=%0d, want %h %b %b",
                 i, codes[i], res, z, ill, tout, e.res, e.z, e.ill);
      end
      tests_run++;
      if (lat !== e.lat || busyc !== 0) begin
        tests_failed++;
        $display("[TB] FAIL op%0d latency: got %0d edges busy=%0d, want %0d busy=0",
                 i, lat, busyc, e.lat);
      end
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL done pulse width: got done=%b, want 0", done);
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  codes[6] = '{4'b1010, 4'b1000, 4'b1000, 4'b1001, 4'b1010, 4'b1000};
    logic [31:0] xs[6]    = '{32'h8000_0000, 32'd1, 32'd3, 32'h8000_0001,
                              32'h7000_0000, 32'h0000_00AB};
    logic [31:0] ys[6]    = '{32'd31, 32'd0, 32'd5, 32'd1, 32'd3, 32'hFFFF_FFE4};
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
    int          busyc;
    bit          tout;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      sbq.push_back(model(codes[i], xs[i], ys[i]));
      run_op(codes[i], xs[i], ys[i], res, z, ill, lat, busyc, tout);
      e = sbq.pop_front();
      tests_run++;
      if (tout || res !== e.res || z !== e.z || ill !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL shift%0d code=%b: got result=%h zero=%b illegal=%b timeout=%0d, want %h %b 0",
                 i, codes[i], res, z, ill, tout, e.res, e.z);
      end
      tests_run++;
      if (lat !== e.lat || busyc !== e.lat - 1) begin
        tests_failed++;
        $display("[TB] FAIL shift%0d timing: got %0d edges busy=%0d, want %0d busy=%0d",
                 i, lat, busyc, e.lat, e.lat - 1);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (done !== 1'b0 || result !== e.res) begin
        tests_failed++;
        $display("[TB] FAIL shift%0d hold: got done=%b result=%h, want 0 %h",
                 i, done, result, e.res);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  codes[3] = '{4'b0010, 4'b0110, 4'b0000};
    logic [31:0] xs[3]    = '{32'd10, 32'd100, 32'hFF00_FF00};
    logic [31:0] ys[3]    = '{32'd20, 32'd1, 32'h0FF0_0FF0};
    exp_t        e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      control_in = codes[i];
      a          = xs[i];
      b          = ys[i];
      start      = 1'b1;
      sbq.push_back(model(codes[i], xs[i], ys[i]));
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      tests_run++;
      if (done !== 1'b1 || result !== e.res || zero !== e.z) begin
        tests_failed++;
        $display("[TB] FAIL b2b%0d: got done=%b result=%h zero=%b, want 1 %h %b",
                 i, done, result, zero, e.res, e.z);
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b end: got done=%b, want 0", done);
    end
  endtask

  task automatic test_start_held();
    int   lat;
    exp_t e;
    @(negedge clk);
    control_in = 4'b1001;
    a          = 32'h0000_00F0;
    b          = 32'd4;
    start      = 1'b1;
    sbq.push_back(model(4'b1001, 32'h0000_00F0, 32'd4));
    sbq.push_back(model(4'b0010, 32'd1, 32'd2));
    @(posedge clk);
    lat = 1;
    #1;
    control_in = 4'b0010;
    a          = 32'd1;
    b          = 32'd2;
    while (done !== 1'b1 && lat < 2 * WIDTH + 4) begin
      @(posedge clk);
      lat++;
      #1;
    end
    e = sbq.pop_front();
    tests_run++;
    if (done !== 1'b1 || lat !== e.lat || result !== e.res) begin
      tests_failed++;
      $display("[TB] FAIL held-start SRL: got done=%b lat=%0d result=%h, want 1 %0d %h",
               done, lat, result, e.lat, e.res);
    end
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    tests_run++;
    if (done !== 1'b1 || result !== e.res || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL held-start ADD in DONE: got done=%b result=%h busy=%b, want 1 %h 0",
               done, result, busy, e.res);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int done_seen;
    @(negedge clk);
    control_in = 4'b1001;
    a          = 32'hFF00_0000;
    b          = 32'd20;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid-shift busy: got %b, want 1", busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (result !== 32'd0 || zero !== 1'b1 || done !== 1'b0 || busy !== 1'b0 ||
        illegal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid-shift reset: got result=%h zero=%b done=%b busy=%b illegal=%b, want 0 1 0 0 0",
               result, zero, done, busy, illegal);
    end
    done_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    tests_run++;
    if (done_seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL aborted shift done: got %0d done cycles, want 0", done_seen);
    end
  endtask

  // Global guard so the run ends even if a task wedges
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    start        = 1'b0;
    control_in   = 4'b0000;
    a            = 32'd0;
    b            = 32'd0;
    test_reset();
    test_single_cycle();
    test_shifts();
    test_back_to_back();
    test_start_held();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
